// File: rtl/pc_ir_unit.sv
// Program-counter / instruction-register stage of the multi-cycle core.
// Holds the fetch PC, latches the fetched instruction word into the IR, and applies
// the control unit's PC-select (hold / increment / relative branch / jump) and
// instruction-load commands each enabled cycle.
// Optional feature macro: RETIRE_CNT_EN adds a saturating 32-bit fetched-instruction
// counter on retire_cnt_out; without it the port is tied to zero.
module pc_ir_unit #(
    parameter int unsigned              DATA_WIDTH = 16,
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            ps_in,
    input  logic                  il_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ins_out,
    output logic [31:0]           retire_cnt_out
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ins_q, ins_d;
    logic [5:0]            br_off;
    logic [ADDR_WIDTH-1:0] br_off_ext;
    logic [ADDR_WIDTH-1:0] jump_target;

    // Branch offset comes from the IR currently held, never from the incoming word.
    assign br_off     = {ins_q[8:6], ins_q[2:0]};
    assign br_off_ext = {{(ADDR_WIDTH-6){br_off[5]}}, br_off};

    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_jump_trunc
        assign jump_target = a_in[ADDR_WIDTH-1:0];
    end else begin : g_jump_zext
        assign jump_target = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, a_in};
    end

    // Next-state for PC and IR; stalled cycles drop the command entirely.
    always_comb begin
        pc_d  = pc_q;
        ins_d = ins_q;
        if (en) begin
            unique case (ps_in)
                2'b00:   pc_d = pc_q;
                2'b01:   pc_d = pc_q + 1'b1;
                2'b10:   pc_d = pc_q + br_off_ext;
                2'b11:   pc_d = jump_target;
                default: pc_d = pc_q;
            endcase
            if (il_in) begin
                ins_d = mem_data_in;
            end
        end
    end

    // PC and IR registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ins_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ins_q <= ins_d;
        end
    end

    assign pc_out  = pc_q;
    assign ins_out = ins_q;

`ifdef RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count enabled instruction loads, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (en && il_in && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt_out = cnt_q;
`else
    assign retire_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: a spec-level model checked every cycle plus
// directed vectors with literal expectations. Honours RETIRE_CNT_EN when defined.
module tb_pc_ir_unit;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [1:0]    ps_in;
    logic          il_in;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] a_in;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ins_out;
    logic [31:0]   retire_cnt_out;

    int passed = 0;
    int total  = 0;
    bit cmp_on = 0;

    // Model state
    int       m_pc;
    int       m_ir;
    longint   m_cnt;

    pc_ir_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .ps_in          (ps_in),
        .il_in          (il_in),
        .mem_data_in    (mem_data_in),
        .a_in           (a_in),
        .pc_out         (pc_out),
        .ins_out        (ins_out),
        .retire_cnt_out (retire_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset = 6-bit signed value built from IR bits 8:6 (high) and 2:0 (low).
    function automatic int next_pc(int pc, int ps, int ir, int a);
        int off;
        int p;
        case (ps)
            1:       p = pc + 1;
            2: begin
                off = (((ir >> 6) & 7) * 8) + (ir & 7);
                if (off >= 32) off = off - 64;
                p = pc + off;
            end
            3:       p = a % 65536;
            default: p = pc;
        endcase
        return (p + 65536) % 65536;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  <= 0;
            m_ir  <= 0;
            m_cnt <= 0;
        end else if (en) begin
            m_pc <= next_pc(m_pc, int'(ps_in), m_ir, int'(a_in));
            if (il_in) m_ir <= int'(mem_data_in);
`ifdef RETIRE_CNT_EN
            if (il_in) m_cnt <= (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_pc",  32'(pc_out),  32'(m_pc));
            check("model_ir",  32'(ins_out), 32'(m_ir));
            check("model_cnt", retire_cnt_out, m_cnt[31:0]);
        end
    end

    task automatic step(input logic e, input logic [1:0] ps, input logic il,
                        input logic [15:0] mem, input logic [15:0] a);
        en          = e;
        ps_in       = ps;
        il_in       = il;
        mem_data_in = mem;
        a_in        = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ps_in = 2'b00; il_in = 1'b0;
        mem_data_in = '0; a_in = '0;
        #2;
        check("reset_pc",  32'(pc_out),  32'h0);
        check("reset_ir",  32'(ins_out), 32'h0);
        check("reset_cnt", retire_cnt_out, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Jump to 0x0010, then fetch 0x1234 with hold, then increment
        step(1, 2'b11, 0, 16'h0000, 16'h0010);
        check("jump_0010", 32'(pc_out), 32'h0010);
        step(1, 2'b00, 1, 16'h1234, 16'h0000);
        check("fetch_ir",   32'(ins_out), 32'h1234);
        check("fetch_hold", 32'(pc_out),  32'h0010);
        step(1, 2'b01, 0, 16'h0000, 16'h0000);
        check("incr_0011", 32'(pc_out), 32'h0011);
        check("ir_holds",  32'(ins_out), 32'h1234);

        // Backward branch: offset 111110 (-2) from 0x0020
        step(1, 2'b11, 1, 16'h01C6, 16'h0020);
        step(1, 2'b10, 0, 16'h0000, 16'h0000);
        check("branch_back", 32'(pc_out), 32'h001E);

        // Forward branch: offset 011111 (+31) from 0x0020
        step(1, 2'b11, 1, 16'h00C7, 16'h0020);
        step(1, 2'b10, 0, 16'h0000, 16'h0000);
        check("branch_fwd", 32'(pc_out), 32'h003F);

        // Jump and wrap cases
        step(1, 2'b11, 0, 16'h0000, 16'hBEEF);
        check("jump_beef", 32'(pc_out), 32'hBEEF);
        step(1, 2'b11, 0, 16'h0000, 16'hFFFF);
        step(1, 2'b01, 0, 16'h0000, 16'h0000);
        check("wrap_inc", 32'(pc_out), 32'h0000);
        step(1, 2'b00, 1, 16'h01C7, 16'h0000);
        step(1, 2'b10, 0, 16'h0000, 16'h0000);
        check("wrap_branch", 32'(pc_out), 32'hFFFF);

        // Stall discards the command
        step(0, 2'b01, 1, 16'hAAAA, 16'h0000);
        check("stall_pc", 32'(pc_out),  32'hFFFF);
        check("stall_ir", 32'(ins_out), 32'h01C7);

        // Simultaneous load and branch: PC uses the old offset (-1)
        step(1, 2'b10, 1, 16'h00C7, 16'h0000);
        check("simul_pc", 32'(pc_out),  32'hFFFE);
        check("simul_ir", 32'(ins_out), 32'h00C7);

        // Asynchronous reset mid-cycle with PC=0x0042
        step(1, 2'b11, 0, 16'h0000, 16'h0042);
        check("pre_reset_pc", 32'(pc_out), 32'h0042);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc_out),  32'h0000);
        check("async_rst_ir", 32'(ins_out), 32'h0000);
        check("async_rst_cnt", retire_cnt_out, 32'h0);
        #2 rst_n = 1'b1;

        // Five load pulses, one stalled
        step(1, 2'b01, 1, 16'h1111, 16'h0000);
        check("post_reset_pc", 32'(pc_out), 32'h0001);
        step(1, 2'b00, 1, 16'h2222, 16'h0000);
        step(0, 2'b00, 1, 16'h3333, 16'h0000);
        step(1, 2'b00, 1, 16'h4444, 16'h0000);
        step(1, 2'b00, 1, 16'h5555, 16'h0000);
        step(1, 2'b00, 0, 16'h0000, 16'h0000);
        check("last_ir", 32'(ins_out), 32'h5555);
`ifdef RETIRE_CNT_EN
        check("retire_cnt", retire_cnt_out, 32'd4);
`else
        check("retire_cnt", retire_cnt_out, 32'd0);
`endif

        @(negedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Program-counter and instruction-register stage for the multi-cycle core; sits directly upstream of the control unit.
- Holds the PC and drives it as the instruction-fetch address.
- Latches the fetched instruction word into the IR, which feeds the control unit's instruction input.
- Applies the control unit's PC-select and instruction-load commands each cycle: hold, increment, relative branch or register jump.

Parameters:
- DATA_WIDTH, 16, width of instruction word, memory data and A-bus.
- ADDR_WIDTH, 16, width of PC and instruction address.
- RESET_PC, 0, PC value loaded on reset; ADDR_WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  stage enable; 0 = memory wait, all registers hold.
- ps_in  in  2  PC select: 00 hold, 01 increment, 10 relative branch, 11 jump.
- il_in  in  1  instruction load; 1 = IR captures mem_data_in.
- mem_data_in  in  DATA_WIDTH  instruction word read from memory.
- a_in  in  DATA_WIDTH  register-file A bus (R[SA]), used as jump target.
- pc_out  out  ADDR_WIDTH  current PC / fetch address.
- ins_out  out  DATA_WIDTH  IR contents, fed to control unit ins_in.
- retire_cnt_out  out  32  fetched-instruction count (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: pc_out=RESET_PC, ins_out=0, retire_cnt_out=0, regardless of clk.
  - Reset asserted mid-operation aborts the pending update immediately.
  - First edge after release performs a normal update.
- Registered outputs: pc_out and ins_out change only on rising clk; no combinational path from inputs to outputs.
- Update rule, on each rising edge with en=1:
  - ps=00: PC unchanged.
  - ps=01: PC <= PC+1.
  - ps=10: PC <= PC + sign_extend({ins_out[8:6], ins_out[2:0]}).
    - 6-bit two's-complement offset, range -32..+31.
    - Offset is taken from the current IR, not mem_data_in.
  - ps=11: PC <= a_in[ADDR_WIDTH-1:0] if DATA_WIDTH>=ADDR_WIDTH, else zero-extended a_in.
  - il=1: IR <= mem_data_in; il=0: IR holds.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH.
  - 0xFFFF+1 = 0x0000.
  - 0x0000 + (-1) = 0xFFFF.
  - No flag on wrap.
- Independence: il and ps act independently.
  - Both may be active in one cycle: IR loads the new word and PC updates using the old IR offset.
  - The control unit never issues this combination; it is still defined.
- en=0: PC, IR and counter all hold; ps/il for that cycle are discarded, not deferred.
- Multi-cycle instructions: the IR holds across extra execute states (il=0), so the control unit sees a stable opcode.
- Latency: a new PC is visible on pc_out one cycle after the command; a fetched word is visible on ins_out one cycle after il.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined:
  - 32-bit counter increments on each rising edge with en=1 and il=1.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0 by rst_n.
  - Drives retire_cnt_out.
- Undefined: no counter logic; retire_cnt_out tied to 0. Port list is identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-cycle with PC=0x0042 -> pc_out=0x0000 and ins_out=0 immediately, without a clock edge.
- Fetch/increment: mem_data_in=0x1234, il=1, ps=00 -> ins_out=0x1234, PC unchanged; next cycle ps=01 -> PC 0x0010 -> 0x0011.
- Branch backward: PC=0x0020, IR offset bits {DR,SB}=6'b111110 (-2), ps=10 -> PC=0x001E.
- Branch forward: offset 6'b011111 -> PC=0x003F.
- Jump and wrap:
  - ps=11, a_in=0xBEEF -> PC=0xBEEF.
  - PC=0xFFFF with ps=01 -> 0x0000.
  - PC=0x0000 with offset -1 -> 0xFFFF.
- Stall and simultaneous events:
  - en=0 with ps=01, il=1 -> PC and IR unchanged.
  - en=1 with il=1 and ps=10 together -> IR takes the new word, PC uses the old offset.
  - With RETIRE_CNT_EN: 5 il pulses, one of them under en=0 -> retire_cnt_out=4.
